// File: rtl/chimera_pkg.sv
// Shared types and defaults for the wide-port bypass-mode controller.
package chimera_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StSwitch
   } bypass_state_e;

   localparam int unsigned DefMaxWrTxns    = 4;
   localparam int unsigned DefMaxRdTxns    = 4;
   localparam int unsigned DefDrainTimeout = 1024;

   // Counter width able to hold values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/chimera_wide_bypass_ctrl_if.sv
// AW/AR valid/ready handshake bundle on either side of the bypass controller.
interface chimera_wide_bypass_ctrl_if ();

   logic aw_valid;
   logic aw_ready;
   logic ar_valid;
   logic ar_ready;

   modport master (
      output aw_valid,
      output ar_valid,
      input  aw_ready,
      input  ar_ready
   );

   modport slave (
      input  aw_valid,
      input  ar_valid,
      output aw_ready,
      output ar_ready
   );

endinterface

// File: rtl/chimera_txn_tracker.sv
// Outstanding-transaction counter, pending-valid flag and cap check for one
// request/response channel pair.
module chimera_txn_tracker
   import chimera_pkg::*;
#(
   parameter  int unsigned MaxTxns = 4,
   localparam int unsigned CntW    = cnt_width(MaxTxns)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   input  logic            req_ready_i,
   input  logic            rsp_hs_i,
   output logic [CntW-1:0] cnt_o,
   output logic            inflight_o,
   output logic            below_cap_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

   logic            req_hs;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            inflight_q, inflight_d;

   assign req_hs = req_valid_i & req_ready_i;

   always_comb begin
      cnt_d = cnt_q;
      if (req_hs && !rsp_hs_i) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!req_hs && rsp_hs_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // A valid seen without ready must be allowed through until it completes.
   always_comb begin
      inflight_d = inflight_q;
      if (req_valid_i && !req_ready_i) begin
         inflight_d = 1'b1;
      end else if (req_hs) begin
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign inflight_o  = inflight_q;
   assign below_cap_o = (cnt_q < MaxCnt);

   underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_hs_i && !req_hs && (cnt_q == '0)));

   overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
      !(req_hs && !rsp_hs_i && (cnt_q == MaxCnt)));

endmodule

// File: rtl/chimera_wide_bypass_ctrl.sv
// Sequences wide-port bypass-mode changes: blocks new AW/AR, drains outstanding
// traffic, switches the demux select, then reopens. Also caps outstanding txns.
module chimera_wide_bypass_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned MaxWrTxns      = DefMaxWrTxns,
   parameter int unsigned MaxRdTxns      = DefMaxRdTxns,
   parameter int unsigned DrainTimeout   = DefDrainTimeout,
   parameter logic        BypassResetVal = 1'b0
) (
   input  logic                              soc_clk_i,
   input  logic                              rst_i,
   input  logic                              bypass_req_i,
   output logic                              bypass_mode_o,
   output logic                              busy_o,
   output logic                              timeout_err_o,
   input  logic                              err_clr_i,
   chimera_wide_bypass_ctrl_if.slave         slv,
   chimera_wide_bypass_ctrl_if.master        mst,
   input  logic                              b_valid_i,
   input  logic                              b_ready_i,
   input  logic                              r_valid_i,
   input  logic                              r_ready_i,
   input  logic                              r_last_i
);

   localparam int unsigned WrCntW = cnt_width(MaxWrTxns);
   localparam int unsigned RdCntW = cnt_width(MaxRdTxns);
   localparam int unsigned TmoW   = cnt_width(DrainTimeout);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(DrainTimeout - 1);

   bypass_state_e state_q, state_d;
   logic          target_q, target_d;
   logic          mode_q, mode_d;
   logic          err_q, err_d;
   logic          err_set;
   logic [TmoW-1:0] tmo_q, tmo_d;

   logic [WrCntW-1:0] wr_cnt;
   logic [RdCntW-1:0] rd_cnt;
   logic              aw_inflight, ar_inflight;
   logic              wr_below_cap, rd_below_cap;
   logic              allow_aw, allow_ar;
   logic              b_hs, r_done;
   logic              drained;

   assign b_hs   = b_valid_i & b_ready_i;
   assign r_done = r_valid_i & r_ready_i & r_last_i;

   chimera_txn_tracker #(
      .MaxTxns (MaxWrTxns)
   ) u_wr_trk (
      .clk_i       (soc_clk_i),
      .rst_i       (rst_i),
      .req_valid_i (mst.aw_valid),
      .req_ready_i (mst.aw_ready),
      .rsp_hs_i    (b_hs),
      .cnt_o       (wr_cnt),
      .inflight_o  (aw_inflight),
      .below_cap_o (wr_below_cap)
   );

   chimera_txn_tracker #(
      .MaxTxns (MaxRdTxns)
   ) u_rd_trk (
      .clk_i       (soc_clk_i),
      .rst_i       (rst_i),
      .req_valid_i (mst.ar_valid),
      .req_ready_i (mst.ar_ready),
      .rsp_hs_i    (r_done),
      .cnt_o       (rd_cnt),
      .inflight_o  (ar_inflight),
      .below_cap_o (rd_below_cap)
   );

   // An already-presented valid is never withdrawn, whatever the state.
   assign allow_aw = aw_inflight | ((state_q == StIdle) & wr_below_cap);
   assign allow_ar = ar_inflight | ((state_q == StIdle) & rd_below_cap);

   assign mst.aw_valid = slv.aw_valid & allow_aw;
   assign slv.aw_ready = mst.aw_ready & allow_aw;
   assign mst.ar_valid = slv.ar_valid & allow_ar;
   assign slv.ar_ready = mst.ar_ready & allow_ar;

   assign drained = (wr_cnt == '0) & (rd_cnt == '0) & ~aw_inflight & ~ar_inflight;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      mode_d   = mode_q;
      tmo_d    = tmo_q;
      err_set  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bypass_req_i != mode_q) begin
               target_d = bypass_req_i;
               tmo_d    = '0;
               state_d  = StDrain;
            end
         end
         StDrain: begin
            // Mode is registered on entry to SWITCH so the demux sees it one
            // cycle before traffic reopens.
            if (drained) begin
               mode_d  = target_q;
               state_d = StSwitch;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
               if ((DrainTimeout != 0) && (tmo_q == TmoLast)) begin
                  err_set = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StSwitch: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign err_d = err_set | (err_q & ~err_clr_i);

   always_ff @(posedge soc_clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         target_q <= BypassResetVal;
         mode_q   <= BypassResetVal;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bypass_mode_o = mode_q;
   assign busy_o        = (state_q != StIdle);
   assign timeout_err_o = err_q;

endmodule

// File: tb/tb_chimera_wide_bypass_ctrl.sv
// Scoreboard bench: stimulus queues expected downstream AW/AR handshakes
// (cycle and mode), a negedge monitor pops and checks them.
module tb_chimera_wide_bypass_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, bypass_req, err_clr;
   logic b_valid, b_ready, r_valid, r_ready, r_last;
   logic bypass_mode, busy, timeout_err;

   chimera_wide_bypass_ctrl_if slv_if ();
   chimera_wide_bypass_ctrl_if mst_if ();

   chimera_wide_bypass_ctrl #(
      .MaxWrTxns      (4),
      .MaxRdTxns      (4),
      .DrainTimeout   (16),
      .BypassResetVal (1'b0)
   ) dut (
      .soc_clk_i     (clk),
      .rst_i         (rst),
      .bypass_req_i  (bypass_req),
      .bypass_mode_o (bypass_mode),
      .busy_o        (busy),
      .timeout_err_o (timeout_err),
      .err_clr_i     (err_clr),
      .slv           (slv_if),
      .mst           (mst_if),
      .b_valid_i     (b_valid),
      .b_ready_i     (b_ready),
      .r_valid_i     (r_valid),
      .r_ready_i     (r_ready),
      .r_last_i      (r_last)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int   cyc;
      logic mode;
   } exp_t;

   exp_t aw_q[$];
   exp_t ar_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push_aw(input int c, input logic m);
      exp_t e;
      e.cyc  = c;
      e.mode = m;
      aw_q.push_back(e);
   endtask

   task automatic push_ar(input int c, input logic m);
      exp_t e;
      e.cyc  = c;
      e.mode = m;
      ar_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every downstream handshake must match the next expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b0) begin
         if (mst_if.aw_valid === 1'b1 && mst_if.aw_ready === 1'b1) begin
            if (aw_q.size() > 0) e = aw_q.pop_front();
            else begin e.cyc = -1; e.mode = 1'b0; end
            chk("aw_hs_cycle", cyc, e.cyc);
            chk("aw_hs_mode", bypass_mode, e.mode);
         end
         if (mst_if.ar_valid === 1'b1 && mst_if.ar_ready === 1'b1) begin
            if (ar_q.size() > 0) e = ar_q.pop_front();
            else begin e.cyc = -1; e.mode = 1'b0; end
            chk("ar_hs_cycle", cyc, e.cyc);
            chk("ar_hs_mode", bypass_mode, e.mode);
         end
      end
   end

   initial begin
      int c0, q, base, u;
      rst = 1'b1; bypass_req = 1'b0; err_clr = 1'b0;
      b_valid = 1'b0; b_ready = 1'b1; r_valid = 1'b0; r_ready = 1'b1; r_last = 1'b0;
      slv_if.aw_valid = 1'b0; slv_if.ar_valid = 1'b0;
      mst_if.aw_ready = 1'b1; mst_if.ar_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_mode", bypass_mode, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_wr_cnt", dut.u_wr_trk.cnt_o, 0);
      chk("rst_rd_cnt", dut.u_rd_trk.cnt_o, 0);
      chk("rst_aw_ready", slv_if.aw_ready, 1);

      // Idle-bus mode change 0->1, AW presented the cycle after the request
      tick();
      c0 = cyc;
      bypass_req = 1'b1;
      tick();
      chk("t1_busy_c1", busy, 1);
      chk("t1_mode_c1", bypass_mode, 0);
      slv_if.aw_valid = 1'b1;
      push_aw(c0 + 3, 1'b1);
      #1;
      chk("t1_aw_blocked", slv_if.aw_ready, 0);
      tick();
      chk("t1_busy_c2", busy, 1);
      chk("t1_mode_c2", bypass_mode, 1);
      tick();
      chk("t1_busy_c3", busy, 0);
      tick();
      slv_if.aw_valid = 1'b0;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;

      // Drain 2 writes and 1 read, new AW/AR blocked throughout DRAIN
      tick();
      slv_if.aw_valid = 1'b1; slv_if.ar_valid = 1'b1;
      push_aw(cyc, 1'b1); push_ar(cyc, 1'b1);
      tick();
      slv_if.ar_valid = 1'b0;
      push_aw(cyc, 1'b1);
      tick();
      slv_if.aw_valid = 1'b0;
      q = cyc;
      bypass_req = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         b_valid = (k == 5 || k == 6);
         r_valid = (k == 8);
         r_last  = (k == 8);
         if (k == 1) begin
            slv_if.aw_valid = 1'b1; slv_if.ar_valid = 1'b1;
            push_aw(q + 11, 1'b0); push_ar(q + 11, 1'b0);
         end
         if (k == 12) begin
            slv_if.aw_valid = 1'b0; slv_if.ar_valid = 1'b0;
         end
         #1;
         chk("t2_busy", busy, 32'(k <= 10));
         chk("t2_mode", bypass_mode, 32'(k <= 9));
         chk("t2_aw_ready", slv_if.aw_ready, 32'(k >= 11));
         chk("t2_ar_ready", slv_if.ar_ready, 32'(k >= 11));
      end
      tick();
      b_valid = 1'b1; r_valid = 1'b1; r_last = 1'b1;
      tick();
      b_valid = 1'b0; r_valid = 1'b0; r_last = 1'b0;

      // AW stalled downstream when the request arrives: completes in DRAIN
      base = cyc + 1;
      for (int k = 0; k <= 9; k++) begin
         tick();
         slv_if.aw_valid = (k <= 3);
         mst_if.aw_ready = (k >= 3);
         bypass_req      = (k >= 1);
         b_valid         = (k == 6);
         if (k == 3) push_aw(base + 3, 1'b0);
         #1;
         chk("t3_busy", busy, 32'(k >= 2 && k <= 8));
         chk("t3_mode", bypass_mode, 32'(k >= 8));
         chk("t3_mst_aw_valid", mst_if.aw_valid, 32'(k <= 3));
      end

      // Outstanding-write cap, including simultaneous AW and B at the cap
      base = cyc + 1;
      for (int k = 0; k <= 10; k++) begin
         logic acc;
         tick();
         slv_if.aw_valid = 1'b1;
         b_valid = (k == 5 || k == 7 || k == 8);
         acc = (k <= 3 || k == 6 || k == 8 || k == 9);
         if (acc) push_aw(base + k, 1'b1);
         #1;
         chk("t4_aw_ready", slv_if.aw_ready, 32'(acc));
         chk("t4_mst_aw_valid", mst_if.aw_valid, 32'(acc));
         if (k == 9) chk("t4_wr_cnt_same_cycle", dut.u_wr_trk.cnt_o, 3);
      end
      tick();
      slv_if.aw_valid = 1'b0;
      b_valid = 1'b1;
      repeat (4) tick();
      b_valid = 1'b0;
      chk("t4_wr_cnt_drained", dut.u_wr_trk.cnt_o, 0);

      // Drain timeout with a B that never returns; clear, then clear vs set
      tick();
      slv_if.aw_valid = 1'b1;
      push_aw(cyc, 1'b1);
      tick();
      slv_if.aw_valid = 1'b0;
      bypass_req = 1'b0;
      u = cyc;
      for (int k = 1; k <= 36; k++) begin
         tick();
         err_clr = (k == 18 || k == 33);
         #1;
         chk("t5_err", timeout_err, 32'(k == 17 || k == 18 || k >= 34));
         chk("t5_busy", busy, 32'(!(k == 17 || k == 34)));
         chk("t5_mode", bypass_mode, 1);
      end
      chk("t5_elapsed", cyc - u, 36);

      // Reset in the middle of DRAIN
      tick();
      err_clr = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_mode", bypass_mode, 0);
      chk("t6_err", timeout_err, 0);
      chk("t6_wr_cnt", dut.u_wr_trk.cnt_o, 0);
      chk("t6_rd_cnt", dut.u_rd_trk.cnt_o, 0);
      tick();
      chk("t6_busy_after", busy, 0);
      slv_if.aw_valid = 1'b1;
      push_aw(cyc, 1'b0);
      tick();
      slv_if.aw_valid = 1'b0;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();

      chk("aw_q_empty", aw_q.size(), 0);
      chk("ar_q_empty", ar_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
